dec_stage: RTL and testbench
============================

# dec_stage

Instruction decode stage of the single-cycle datapath, directly upstream of the ALU stage. Holds the 32×32-bit register file and extracts register addresses from the instruction word. Supplies the ALU stage's `rfa`, `rfb` and `immed` operands, and writes back either the ALU result or memory read data.

## Interface
Parameters:
- `RF_DEPTH`, 32: number of architectural registers; index width is log2(RF_DEPTH) = 5.
- `DW`, 32: data width.

Ports:
- `Clk`  in  1: single clock; all state updates on the rising edge.
- `Rst`  in  1: reset, asynchronous, active-high.
- `Instr`  in  32: current instruction. Fields: rs=[25:21], rd=[20:16], rt=[15:11], imm16=[15:0].
- `RF_WrEn`  in  1: register write enable.
- `RF_WrData_sel`  in  1: write-data source; 0 = `ALU_out`, 1 = `MEM_out`.
- `RF_B_sel`  in  1: read port B address; 0 = rt, 1 = rd.
- `ImmExt`  in  2: immediate mode; 00 zero-extend, 01 sign-extend, 10 imm16<<16 (low half zero), 11 sign-extend then <<2.
- `ALU_out`  in  32: result from the ALU stage.
- `MEM_out`  in  32: read data from the memory stage.
- `Immed`  out  32: extended immediate.
- `RF_A`  out  32: register[rs].
- `RF_B`  out  32: register[rt or rd].

## Operation
- Read port A address is rs. Read port B address is `RF_B_sel ? rd : rt`. Both reads are combinational.
- Write address is always rd.
- Write data is `RF_WrData_sel ? MEM_out : ALU_out`.
- Write occurs on the rising `Clk` edge when `RF_WrEn`=1 and rd≠0.
- Register 0 reads as 0 at all times. A write to R0 is discarded; no storage is updated.
- `Immed` is purely combinational from `Instr[15:0]` and `ImmExt`:
  - Mode 11 result is {{14{imm[15]}}, imm, 2'b00}; shifted-out sign bits are dropped.
  - Mode 10 ignores the sign.
- Simultaneous read and write to the same non-zero register:
  - Without bypass: the read returns the old value until the edge.
  - With bypass: see Configuration.

## Timing
- `Rst` asserted: all registers clear to 0 immediately, without waiting for `Clk`. `RF_A`/`RF_B` therefore read 0 while reset is held. `Immed` is unaffected by reset.
- `Rst` deasserted: the first write can occur on the next rising edge.
- `Rst` asserted in the same cycle as a write: reset wins; the register remains 0.
- Write latency is 1 cycle. A value written at edge N is visible on the read ports after edge N (combinational settle).
- Read latency from `Instr`, `RF_B_sel` or `ImmExt` to the outputs is 0 cycles (combinational).
- `RF_WrEn`=0: no state changes, regardless of the other inputs.

## Configuration
- `DEC_STAGE_BYPASS_EN` defined:
  - When `RF_WrEn`=1, rd≠0 and a read address equals rd, that port returns the current write data combinationally instead of the stored value.
  - Bypass is gated by `Rst`: the read port returns 0 while reset is asserted.
- Macro undefined: no bypass path. Reads always return stored contents.

## Structure
- Shared package `cpu_pkg` holds:
  - `IMM_ZERO`, `IMM_SIGN`, `IMM_HI16`, `IMM_SIGN_SH2` (2-bit encodings of `ImmExt`).
  - Field position constants for rs/rd/rt/imm.
  - Write-data select encodings `WB_ALU`=0 and `WB_MEM`=1.
- One natural sub-module, `register_file`:
  - Two combinational read ports, one synchronous write port, asynchronous reset, R0 forced to zero.
  - Bypass logic lives inside it.
- `dec_stage` adds the address muxing, write-data mux and immediate extender.

## Test plan
- Reset: write 0xDEADBEEF to R5, then assert `Rst` mid-cycle. `RF_A` for rs=5 drops to 0 before the next edge.
- Write/read: `RF_WrEn`=1, rd=7, `ALU_out`=0x12345678, sel=0, one edge. With rs=7, `RF_A`=0x12345678.
- Memory path: `RF_WrData_sel`=1, `MEM_out`=0xA5A5A5A5, rd=3, one edge. With `RF_B_sel`=1 and rd=3, `RF_B`=0xA5A5A5A5.
- R0 protection: write 0xFFFFFFFF to rd=0. `RF_A` with rs=0 stays 0x00000000.
- Immediate modes, imm16=0x8001:
  - 00 → 0x00008001
  - 01 → 0xFFFF8001
  - 10 → 0x80010000
  - 11 → 0xFFFE0004
- Same-cycle read/write, rd=rs=9, stored 0x11, writing 0x22:
  - Bypass off: `RF_A`=0x11 before the edge.
  - Bypass on: `RF_A`=0x22.
  - Both: 0x22 after the edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: immediate modes, instruction field positions
// and write-back source encodings.
package cpu_pkg;

  // ImmExt encodings
  localparam logic [1:0] IMM_ZERO     = 2'b00;
  localparam logic [1:0] IMM_SIGN     = 2'b01;
  localparam logic [1:0] IMM_HI16     = 2'b10;
  localparam logic [1:0] IMM_SIGN_SH2 = 2'b11;

  // Instruction field positions
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RD_MSB  = 20;
  localparam int unsigned RD_LSB  = 16;
  localparam int unsigned RT_MSB  = 15;
  localparam int unsigned RT_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  // Write-back data source select
  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/register_file.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous active-high reset, R0 hard-wired to zero.
// Optional same-cycle write-to-read forwarding under DEC_STAGE_BYPASS_EN.
module register_file #(
  parameter int unsigned RF_DEPTH = 32,
  parameter int unsigned DW       = 32,
  localparam int unsigned AW      = $clog2(RF_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] rd_addr_a_i,
  input  logic [AW-1:0] rd_addr_b_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic [DW-1:0] rd_data_a_o,
  output logic [DW-1:0] rd_data_b_o
);

  logic [DW-1:0] regs_q [RF_DEPTH];
  logic [DW-1:0] regs_d [RF_DEPTH];
  logic          wr_hit;

  // Writes to R0 are dropped so it never holds anything but zero.
  assign wr_hit = wr_en_i && (wr_addr_i != '0);

  // Next-state: update the addressed entry on a qualifying write.
  always_comb begin
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[wr_addr_i] = wr_data_i;
    end
    regs_d[0] = '0;
  end

  // Storage, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads, with optional forwarding of the in-flight write.
  always_comb begin
    rd_data_a_o = (rd_addr_a_i == '0) ? '0 : regs_q[rd_addr_a_i];
    rd_data_b_o = (rd_addr_b_i == '0) ? '0 : regs_q[rd_addr_b_i];
`ifdef DEC_STAGE_BYPASS_EN
    if (wr_hit && (rd_addr_a_i == wr_addr_i)) begin
      rd_data_a_o = wr_data_i;
    end
    if (wr_hit && (rd_addr_b_i == wr_addr_i)) begin
      rd_data_b_o = wr_data_i;
    end
    // Forwarded data must not leak out while storage is held in reset.
    if (rst_i) begin
      rd_data_a_o = '0;
      rd_data_b_o = '0;
    end
`endif
  end

endmodule

// File: rtl/dec_stage.sv
// Instruction decode stage: register address extraction, write-back data mux,
// immediate extender and the register file.
// Optional feature macro: DEC_STAGE_BYPASS_EN (same-cycle write forwarding).
module dec_stage
  import cpu_pkg::*;
#(
  parameter int unsigned RF_DEPTH = 32,
  parameter int unsigned DW       = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [31:0]   Instr,
  input  logic          RF_WrEn,
  input  logic          RF_WrData_sel,
  input  logic          RF_B_sel,
  input  logic [1:0]    ImmExt,
  input  logic [DW-1:0] ALU_out,
  input  logic [DW-1:0] MEM_out,
  output logic [DW-1:0] Immed,
  output logic [DW-1:0] RF_A,
  output logic [DW-1:0] RF_B
);

  localparam int unsigned AW = $clog2(RF_DEPTH);

  logic [AW-1:0] rs, rd, rt, addr_b;
  logic [15:0]   imm16;
  logic [DW-1:0] wr_data;
  logic          unused_instr;

  assign rs    = Instr[RS_MSB:RS_LSB];
  assign rd    = Instr[RD_MSB:RD_LSB];
  assign rt    = Instr[RT_MSB:RT_LSB];
  assign imm16 = Instr[IMM_MSB:IMM_LSB];

  // Opcode bits are decoded elsewhere.
  assign unused_instr = ^Instr[31:26];

  // Port B address and write-back source selection.
  always_comb begin
    addr_b  = RF_B_sel ? rd : rt;
    wr_data = (RF_WrData_sel == WB_MEM) ? MEM_out : ALU_out;
  end

  // Immediate extension; mode 11 drops the top two sign bits after the shift.
  always_comb begin
    Immed = '0;
    unique case (ImmExt)
      IMM_ZERO:     Immed = {{(DW-16){1'b0}}, imm16};
      IMM_SIGN:     Immed = {{(DW-16){imm16[15]}}, imm16};
      IMM_HI16:     Immed = {imm16, {(DW-16){1'b0}}};
      IMM_SIGN_SH2: Immed = {{(DW-18){imm16[15]}}, imm16, 2'b00};
      default:      Immed = '0;
    endcase
  end

  register_file #(
    .RF_DEPTH (RF_DEPTH),
    .DW       (DW)
  ) u_register_file (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .rd_addr_a_i (rs),
    .rd_addr_b_i (addr_b),
    .wr_en_i     (RF_WrEn),
    .wr_addr_i   (rd),
    .wr_data_i   (wr_data),
    .rd_data_a_o (RF_A),
    .rd_data_b_o (RF_B)
  );

endmodule

// File: tb/tb_dec_stage.sv
// Self-checking bench for dec_stage: directed cases followed by randomized
// traffic compared against a behavioural register-file/immediate model.
module tb_dec_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] Instr;
  logic        RF_WrEn;
  logic        RF_WrData_sel;
  logic        RF_B_sel;
  logic [1:0]  ImmExt;
  logic [31:0] ALU_out;
  logic [31:0] MEM_out;
  logic [31:0] Immed;
  logic [31:0] RF_A;
  logic [31:0] RF_B;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  dec_stage dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Instr         (Instr),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ImmExt        (ImmExt),
    .ALU_out       (ALU_out),
    .MEM_out       (MEM_out),
    .Immed         (Immed),
    .RF_A          (RF_A),
    .RF_B          (RF_B)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rs, input int rd, input logic [15:0] imm);
    logic [4:0] s, d;
    s = rs[4:0];
    d = rd[4:0];
    return {6'b0, s, d, imm};
  endfunction

  function automatic int f_rs();
    return int'(Instr[25:21]);
  endfunction

  function automatic int f_rd();
    return int'(Instr[20:16]);
  endfunction

  function automatic int f_rt();
    return int'(Instr[15:11]);
  endfunction

  function automatic logic [31:0] wdata();
    return RF_WrData_sel ? MEM_out : ALU_out;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Value a read port should show for register a given the current inputs.
  function automatic logic [31:0] exp_read(input int a);
    if (Rst || a == 0) return 32'h0;
`ifdef DEC_STAGE_BYPASS_EN
    if (RF_WrEn && a == f_rd()) return wdata();
`endif
    return model[a];
  endfunction

  function automatic logic [31:0] exp_imm();
    int unsigned u;
    int          s;
    logic [15:0] imm;
    imm = Instr[15:0];
    u   = int'(imm);
    s   = $signed(imm);
    case (ImmExt)
      2'd0:    return u;
      2'd1:    return s;
      2'd2:    return u * 65536;
      default: return s * 4;
    endcase
  endfunction

  // One rising edge, then return at the following falling edge.
  task automatic tick();
    @(posedge Clk);
    if (Rst) clear_model();
    else if (RF_WrEn && f_rd() != 0) model[f_rd()] = wdata();
    @(negedge Clk);
  endtask

  task automatic check_ports(input string tag);
    int b;
    b = RF_B_sel ? f_rd() : f_rt();
    check_eq({tag, "_rf_a"}, RF_A, exp_read(f_rs()));
    check_eq({tag, "_rf_b"}, RF_B, exp_read(b));
    check_eq({tag, "_immed"}, Immed, exp_imm());
  endtask

  initial begin
    Rst = 1'b1; Instr = '0; RF_WrEn = 1'b0; RF_WrData_sel = 1'b0; RF_B_sel = 1'b0;
    ImmExt = 2'b00; ALU_out = '0; MEM_out = '0;
    clear_model();

    // Reset state
    Instr = mk_instr(5, 6, 16'h3800);
    #1;
    check_eq("reset_rf_a", RF_A, 32'h0);
    check_eq("reset_rf_b", RF_B, 32'h0);
    @(negedge Clk);
    tick();
    Rst = 1'b0;

    // Write R5 then assert reset mid-cycle; reads must drop before the next edge
    Instr = mk_instr(0, 5, 16'h0); RF_WrEn = 1'b1; ALU_out = 32'hDEADBEEF;
    tick();
    RF_WrEn = 1'b0; Instr = mk_instr(5, 0, 16'h0);
    #1;
    check_eq("r5_written", RF_A, 32'hDEADBEEF);
    #1;
    Rst = 1'b1;
    clear_model();
    #1;
    check_eq("rst_async", RF_A, 32'h0);
    // Reset wins over a simultaneous write
    Instr = mk_instr(5, 5, 16'h0); RF_WrEn = 1'b1; ALU_out = 32'hCAFEF00D;
    #1;
    check_eq("rst_gates_read", RF_A, 32'h0);
    tick();
    Rst = 1'b0; RF_WrEn = 1'b0;
    #1;
    check_eq("rst_wins", RF_A, 32'h0);

    // ALU write path
    @(negedge Clk);
    Instr = mk_instr(0, 7, 16'h0); RF_WrEn = 1'b1; RF_WrData_sel = 1'b0;
    ALU_out = 32'h12345678; MEM_out = 32'h0BADF00D;
    tick();
    RF_WrEn = 1'b0; Instr = mk_instr(7, 0, 16'h0);
    #1;
    check_eq("alu_wb", RF_A, 32'h12345678);

    // Memory write path, read back on port B via rd
    @(negedge Clk);
    Instr = mk_instr(0, 3, 16'h0); RF_WrEn = 1'b1; RF_WrData_sel = 1'b1;
    MEM_out = 32'hA5A5A5A5; ALU_out = 32'h5A5A5A5A;
    tick();
    RF_WrEn = 1'b0; RF_B_sel = 1'b1;
    #1;
    check_eq("mem_wb", RF_B, 32'hA5A5A5A5);

    // R0 protection
    @(negedge Clk);
    RF_B_sel = 1'b0; RF_WrData_sel = 1'b0;
    Instr = mk_instr(0, 0, 16'h0); RF_WrEn = 1'b1; ALU_out = 32'hFFFFFFFF;
    #1;
    check_eq("r0_pre", RF_A, 32'h0);
    tick();
    RF_WrEn = 1'b0;
    #1;
    check_eq("r0_post", RF_A, 32'h0);

    // Immediate modes
    Instr = mk_instr(0, 0, 16'h8001);
    ImmExt = 2'b00; #1; check_eq("imm_zero", Immed, 32'h00008001);
    ImmExt = 2'b01; #1; check_eq("imm_sign", Immed, 32'hFFFF8001);
    ImmExt = 2'b10; #1; check_eq("imm_hi16", Immed, 32'h80010000);
    ImmExt = 2'b11; #1; check_eq("imm_sh2",  Immed, 32'hFFFE0004);

    // Same-cycle read/write of R9
    @(negedge Clk);
    Instr = mk_instr(0, 9, 16'h0); RF_WrEn = 1'b1; ALU_out = 32'h11;
    tick();
    Instr = mk_instr(9, 9, 16'h0); ALU_out = 32'h22;
    #1;
`ifdef DEC_STAGE_BYPASS_EN
    check_eq("same_cycle_pre", RF_A, 32'h22);
`else
    check_eq("same_cycle_pre", RF_A, 32'h11);
`endif
    tick();
    RF_WrEn = 1'b0;
    #1;
    check_eq("same_cycle_post", RF_A, 32'h22);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk);
      Rst           = ($urandom_range(0, 31) == 0);
      Instr         = $urandom;
      RF_WrEn       = $urandom_range(0, 3) != 0;
      RF_WrData_sel = $urandom_range(0, 1) == 1;
      RF_B_sel      = $urandom_range(0, 1) == 1;
      ImmExt        = 2'($urandom_range(0, 3));
      ALU_out       = $urandom;
      MEM_out       = $urandom;
      // Bias addresses into a small window so reads hit recent writes
      if ($urandom_range(0, 1) == 1) begin
        Instr[25:21] = 5'($urandom_range(0, 3));
        Instr[20:16] = 5'($urandom_range(0, 3));
        Instr[15:11] = 5'($urandom_range(0, 3));
      end
      if (Rst) clear_model();
      #1;
      check_ports("rand");
      @(posedge Clk);
      if (Rst) clear_model();
      else if (RF_WrEn && f_rd() != 0) model[f_rd()] = wdata();
    end

    @(negedge Clk);
    Rst = 1'b0; RF_WrEn = 1'b0;
    for (int r = 0; r < 32; r++) begin
      Instr = mk_instr(r, 0, 16'h0);
      #1;
      if (r % 4 == 0) check_eq("final_sweep", RF_A, exp_read(r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
